mem_access_stage: RTL



---
 rtl/mem_access_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage RV32 pipeline: drives the data-memory req/gnt/rvalid
// port for loads and stores, stalls upstream while an access is outstanding,
// and owns the MEM/WB pipeline register.

package mem_access_stage_pkg;

  // EX/MEM bundle (212 bits)
  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        JALSel;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        Zero;
    logic [2:0]  func3;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] RD_Two;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
  } ex_mem_reg;

  // MEM/WB bundle (200 bits)
  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        JALSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
  } mem_wb_reg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_reg   ex_mem,
  output mem_wb_reg   mem_wb,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_wb_reg        mem_wb_q, mem_wb_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;

  logic        memop_c, is_store_c, aligned_c;
  logic        req_c, stall_c, complete_c, abort_c, misal_c, load_done_c;
  logic        timeout_hit_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] load_data_c;

  // Fields carried through EX/MEM for other stages but not consumed here
  logic unused_c;
  assign unused_c = ^{ex_mem.Branch, ex_mem.Zero, ex_mem.rs2};

  assign memop_c       = ex_mem.MemRead | ex_mem.MemWrite;
  assign is_store_c    = ex_mem.MemWrite;
  assign timeout_hit_c = (cnt_q == CNT_LAST);

  // Alignment check by access size
  always_comb begin
    aligned_c = 1'b1;
    case (ex_mem.func3[1:0])
      2'b00:   aligned_c = 1'b1;
      2'b01:   aligned_c = ~ex_mem.Alu_Result[0];
      default: aligned_c = (ex_mem.Alu_Result[1:0] == 2'b00);
    endcase
  end

  // Store lane replication and byte enables; loads read the full word
  always_comb begin
    wdata_c = ex_mem.RD_Two;
    be_c    = 4'b1111;
    if (is_store_c) begin
      case (ex_mem.func3[1:0])
        2'b00: begin
          wdata_c = {4{ex_mem.RD_Two[7:0]}};
          be_c    = 4'b0001 << ex_mem.Alu_Result[1:0];
        end
        2'b01: begin
          wdata_c = {2{ex_mem.RD_Two[15:0]}};
          be_c    = ex_mem.Alu_Result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_c = ex_mem.RD_Two;
          be_c    = 4'b1111;
        end
      endcase
    end
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    ld_byte_c = dmem_rdata[7:0];
    case (ex_mem.Alu_Result[1:0])
      2'd0:    ld_byte_c = dmem_rdata[7:0];
      2'd1:    ld_byte_c = dmem_rdata[15:8];
      2'd2:    ld_byte_c = dmem_rdata[23:16];
      default: ld_byte_c = dmem_rdata[31:24];
    endcase
    ld_half_c = ex_mem.Alu_Result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ex_mem.func3)
      F3_B:    load_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      F3_H:    load_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      F3_W:    load_data_c = dmem_rdata;
      F3_BU:   load_data_c = {24'b0, ld_byte_c};
      F3_HU:   load_data_c = {16'b0, ld_half_c};
      default: load_data_c = dmem_rdata;
    endcase
  end

  // Next-state, counter, MEM/WB capture and error pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    mem_wb_d    = '0;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    req_c       = 1'b0;
    complete_c  = 1'b0;
    abort_c     = 1'b0;
    misal_c     = 1'b0;
    load_done_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop_c) begin
          if (!aligned_c) begin
            misal_c    = 1'b1;
            complete_c = 1'b1;
          end else begin
            req_c = 1'b1;
            if (dmem_gnt) begin
              if (is_store_c) complete_c = 1'b1;
              else            state_d    = S_RESP;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_gnt && is_store_c) begin
          complete_c = 1'b1;
          state_d    = S_IDLE;
          cnt_d      = '0;
        end else if (timeout_hit_c) begin
          abort_c = 1'b1;
        end else if (dmem_gnt) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          complete_c  = 1'b1;
          load_done_c = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else if (timeout_hit_c) begin
          abort_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_c) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b1;
    end
    misalign_d = misal_c;

    stall_c = memop_c & ~complete_c & ~abort_c;

    if (!stall_c) begin
      mem_wb_d.RegWrite    = ex_mem.RegWrite & ~misal_c & ~abort_c;
      mem_wb_d.MemtoReg    = ex_mem.MemtoReg;
      mem_wb_d.JALSel      = ex_mem.JALSel;
      mem_wb_d.Pc_Imm      = ex_mem.Pc_Imm;
      mem_wb_d.Pc_Four     = ex_mem.Pc_Four;
      mem_wb_d.Imm_Out     = ex_mem.Imm_Out;
      mem_wb_d.Alu_Result  = ex_mem.Alu_Result;
      mem_wb_d.MemReadData = load_done_c ? load_data_c : 32'd0;
      mem_wb_d.rd          = ex_mem.rd;
      mem_wb_d.Curr_Instr  = ex_mem.Curr_Instr;
    end
  end

  // State, counter and pipeline register update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_wb_q   <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_wb_q   <= mem_wb_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_wb       = mem_wb_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;
  assign mem_stall    = rst_n & stall_c;
  assign dmem_req     = rst_n & req_c;
  assign dmem_we      = is_store_c;
  assign dmem_addr    = ex_mem.Alu_Result;
  assign dmem_be      = be_c;
  assign dmem_wdata   = wdata_c;

endmodule
